// File: rtl/dram_arb_pkg.sv
// Shared constants for the DRAM port arbiter: FSM encodings, default widths
// and the read-latency counter width.
package dram_arb_pkg;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ISSUE   = 2'd1;
    localparam logic [1:0] WAIT_RD = 2'd2;

    localparam int unsigned ADDR_W_DEF = 16;
    localparam int unsigned DATA_W_DEF = 8;

    // Wide enough to hold RD_LAT-1 for the largest supported latency of 7.
    localparam int unsigned CNT_W = 3;

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin picker: returns the first set bit of i_active
// searching upward from i_ptr+1 with wrap-around.
module rr_select #(
    parameter int unsigned NUM_CORES = 4,
    parameter int unsigned IDX_W     = $clog2(NUM_CORES)
) (
    input  logic [NUM_CORES-1:0] i_active,
    input  logic [IDX_W-1:0]     i_ptr,
    output logic [IDX_W-1:0]     o_idx,
    output logic                 o_found
);

    always_comb begin
        int k;
        k       = 0;
        o_idx   = '0;
        o_found = 1'b0;
        for (int i = 1; i <= int'(NUM_CORES); i++) begin
            k = (int'(i_ptr) + i) % int'(NUM_CORES);
            if (!o_found && i_active[k]) begin
                o_found = 1'b1;
                o_idx   = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/dram_arbiter.sv
// Round-robin arbiter sharing one DRAM port among NUM_CORES cores.
// Define DRAM_ARB_PERF_EN to add per-core saturating grant counters (o_grant_cnt).
module dram_arbiter
    import dram_arb_pkg::*;
#(
    parameter int unsigned NUM_CORES = 4,
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned RD_LAT    = 1
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [NUM_CORES-1:0]          i_req_read,
    input  logic [NUM_CORES-1:0]          i_req_write,
    input  logic [NUM_CORES*ADDR_W-1:0]   i_req_addr,
    input  logic [NUM_CORES*DATA_W-1:0]   i_req_wdata,
    output logic [NUM_CORES-1:0]          o_grant,
    output logic [NUM_CORES-1:0]          o_rvalid,
    output logic [DATA_W-1:0]             o_rdata,
    output logic                          o_busy,
`ifdef DRAM_ARB_PERF_EN
    output logic [NUM_CORES*16-1:0]       o_grant_cnt,
`endif
    output logic [ADDR_W-1:0]             o_mem_addr,
    output logic                          o_mem_read,
    output logic                          o_mem_write,
    output logic [DATA_W-1:0]             o_mem_wdata,
    input  logic [DATA_W-1:0]             i_mem_rdata
);

    localparam int unsigned IDX_W = $clog2(NUM_CORES);
    localparam logic [NUM_CORES-1:0] ONE_HOT0 = NUM_CORES'(1);

    logic [1:0]           r_state;
    logic [IDX_W-1:0]     r_idx;
    logic [IDX_W-1:0]     r_ptr;
    logic                 r_is_write;
    logic [CNT_W-1:0]     r_cnt;
    logic [NUM_CORES-1:0] r_mask;
    logic [NUM_CORES-1:0] r_grant;
    logic [NUM_CORES-1:0] r_rvalid;
    logic [DATA_W-1:0]    r_rdata;
    logic                 r_busy;
    logic [ADDR_W-1:0]    r_mem_addr;
    logic                 r_mem_read;
    logic                 r_mem_write;
    logic [DATA_W-1:0]    r_mem_wdata;

    logic [NUM_CORES-1:0] w_active;
    logic [IDX_W-1:0]     w_idx;
    logic                 w_found;

    // The mask keeps the core just served out for one IDLE cycle while it drops its request.
    assign w_active = (i_req_read | i_req_write) & ~r_mask;

    rr_select #(
        .NUM_CORES (NUM_CORES),
        .IDX_W     (IDX_W)
    ) u_rr_select (
        .i_active (w_active),
        .i_ptr    (r_ptr),
        .o_idx    (w_idx),
        .o_found  (w_found)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_ptr       <= IDX_W'(NUM_CORES - 1);
            r_is_write  <= 1'b0;
            r_cnt       <= '0;
            r_mask      <= '0;
            r_grant     <= '0;
            r_rvalid    <= '0;
            r_rdata     <= '0;
            r_busy      <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_wdata <= '0;
        end else begin
            r_grant     <= '0;
            r_rvalid    <= '0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_mask <= '0;
                    if (w_found) begin
                        r_idx       <= w_idx;
                        r_ptr       <= w_idx;
                        // Write wins when a core raises both strobes.
                        r_is_write  <= i_req_write[w_idx];
                        r_mem_write <= i_req_write[w_idx];
                        r_mem_read  <= ~i_req_write[w_idx];
                        r_mem_addr  <= i_req_addr[w_idx*ADDR_W +: ADDR_W];
                        r_mem_wdata <= i_req_wdata[w_idx*DATA_W +: DATA_W];
                        r_grant     <= ONE_HOT0 << w_idx;
                        r_busy      <= 1'b1;
                        r_state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (r_is_write) begin
                        r_mask  <= ONE_HOT0 << r_idx;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_cnt   <= CNT_W'(RD_LAT - 1);
                        r_state <= WAIT_RD;
                    end
                end
                WAIT_RD: begin
                    if (r_cnt == '0) begin
                        r_rdata  <= i_mem_rdata;
                        r_rvalid <= ONE_HOT0 << r_idx;
                        r_mask   <= ONE_HOT0 << r_idx;
                        r_busy   <= 1'b0;
                        r_state  <= IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_grant     = r_grant;
    assign o_rvalid    = r_rvalid;
    assign o_rdata     = r_rdata;
    assign o_busy      = r_busy;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_read  = r_mem_read;
    assign o_mem_write = r_mem_write;
    assign o_mem_wdata = r_mem_wdata;

`ifdef DRAM_ARB_PERF_EN
    logic [15:0] r_grant_cnt [NUM_CORES];

    always_ff @(posedge i_clk) begin
        for (int k = 0; k < int'(NUM_CORES); k++) begin
            if (!i_rst_n) begin
                r_grant_cnt[k] <= '0;
            end else if (r_grant[k] && (r_grant_cnt[k] != 16'hFFFF)) begin
                r_grant_cnt[k] <= r_grant_cnt[k] + 16'd1;
            end
        end
    end

    for (genvar g = 0; g < int'(NUM_CORES); g++) begin : g_cnt_out
        assign o_grant_cnt[g*16 +: 16] = r_grant_cnt[g];
    end
`endif

endmodule

// File: doc/dram_arbiter.md
Name: dram_arbiter

Overview:
- Shares the single data-RAM port between NUM_CORES matrix-multiplier cores.
- Each core presents a read or write request with address and write data.
- The arbiter picks one core per transaction using round-robin and drives the DRAM port.
- For reads it waits the fixed DRAM read latency, then returns the data with a valid strobe to the requesting core.

Parameters:
- NUM_CORES, 4, number of requesting cores (2..8)
- ADDR_W, 16, DRAM address width
- DATA_W, 8, DRAM data width
- RD_LAT, 1, cycles from o_mem_read high until i_mem_rdata is valid (1..7)

Ports:
- i_clk  in  1  system clock, all logic on rising edge
- i_rst_n  in  1  synchronous active-low reset
- i_req_read  in  NUM_CORES  per-core read request, level, held until grant
- i_req_write  in  NUM_CORES  per-core write request, level, held until grant
- i_req_addr  in  NUM_CORES*ADDR_W  packed addresses; core k at [k*ADDR_W +: ADDR_W]
- i_req_wdata  in  NUM_CORES*DATA_W  packed write data; core k at [k*DATA_W +: DATA_W]
- o_grant  out  NUM_CORES  one-hot, one-cycle pulse; request accepted
- o_rvalid  out  NUM_CORES  one-hot, one-cycle pulse; o_rdata valid for that core
- o_rdata  out  DATA_W  read data, shared by all cores
- o_busy  out  1  high whenever state is not IDLE
- o_mem_addr  out  ADDR_W  DRAM address
- o_mem_read  out  1  DRAM read strobe
- o_mem_write  out  1  DRAM write strobe
- o_mem_wdata  out  DATA_W  DRAM write data
- i_mem_rdata  in  DATA_W  DRAM read data

Behaviour:
- All outputs are registered.
- Reset (i_rst_n=0 at a rising edge, including mid-transaction) clears every output to 0, sets state to IDLE, sets the round-robin pointer to NUM_CORES-1 (so core 0 wins first), and clears the mask. Any in-flight read is dropped with no o_rvalid.
- Core k is "active" when i_req_read[k] | i_req_write[k], and k is not masked.
- If a core asserts both read and write, the write takes precedence and the read is ignored.
- States: IDLE, ISSUE, WAIT_RD.
- IDLE:
  - If any core is active, select the first active core searching ptr+1, ptr+2, ... with wrap modulo NUM_CORES.
  - Register idx, and drive o_mem_addr, o_mem_wdata and either o_mem_read or o_mem_write from that core.
  - Pulse o_grant[idx]; set ptr=idx; go to ISSUE.
  - With no request, stay in IDLE; mem strobes stay 0, and addr/wdata hold their last value.
- ISSUE (strobe and grant visible for exactly this cycle):
  - Write: deassert strobes, set mask=onehot(idx), go to IDLE.
  - Read: deassert strobes, load latency counter with RD_LAT-1, go to WAIT_RD.
- WAIT_RD:
  - When the counter reaches 0, capture i_mem_rdata into o_rdata, pulse o_rvalid[idx], set mask=onehot(idx), go to IDLE.
  - Otherwise decrement the counter.
- Mask lasts exactly the first IDLE cycle after a transaction, then clears. This gives the granted core one cycle to drop its request.
- Requester rule: the core deasserts its request in the cycle after o_grant. For a read, it must not re-request before o_rvalid.
- Latency:
  - Request seen in cycle N gives grant and strobe in N+1.
  - A read returns o_rvalid in N+2+RD_LAT.
- Throughput:
  - A write occupies 2 cycles.
  - A read occupies 2+RD_LAT cycles.
- Requests are not queued. Address and data are sampled only at the grant edge; changes while waiting are ignored.
- o_rdata holds its value until the next read completes.

Optional Feature:
- Macro DRAM_ARB_PERF_EN.
- When defined:
  - Adds output o_grant_cnt, NUM_CORES*16 bits, with core k at [k*16 +: 16].
  - Each counter increments on that core's o_grant and saturates at 16'hFFFF.
  - Counters clear on reset.
- When undefined: the port and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package dram_arb_pkg holds:
  - the state enum (IDLE=2'd0, ISSUE=2'd1, WAIT_RD=2'd2)
  - default width constants ADDR_W_DEF=16 and DATA_W_DEF=8
  - the counter width CNT_W=3
- Sub-module rr_select: combinational round-robin picker.
  - Inputs: active vector, ptr.
  - Outputs: idx and found.
  - Instantiated once.

Test Plan:
- Reset then core 1 writes 8'hA5 to 16'h0040: grant[1] and o_mem_write=1 with addr 16'h0040 and wdata 8'hA5 in the cycle after the request; o_busy falls 2 cycles later.
- Core 2 reads 16'h0100 with RD_LAT=1 and the memory model returning 8'h3C: o_mem_read in cycle N+1; o_rvalid[2]=1 and o_rdata=8'h3C in N+3; no other o_rvalid bit set.
- All 4 cores hold write requests continuously from reset: grants occur in order 0,1,2,3,0 at 2-cycle spacing.
- Core 0 asserts read and write together at addr 16'h0007: only o_mem_write pulses, and no o_rvalid follows.
- Reset asserted during WAIT_RD: all outputs read 0 the next cycle, no o_rvalid, and the next request from core 3 is granted normally.
- With DRAM_ARB_PERF_EN defined, core 1 gets 5 grants: o_grant_cnt for core 1 is 5 and all other counters are 0; force a counter to 16'hFFFF and grant again: it stays 16'hFFFF.
